// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 crop/pack capture path.
package ov5640_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ACTIVE  = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam int COORD_W = 12;
    localparam int FIFO_W  = 34;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [31:0] data;
    } word_t;

    // Coordinates stick at the top value instead of wrapping.
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (&v) ? v : v + COORD_W'(1);
    endfunction

endpackage

// File: rtl/ov5640_crop_pack_if.sv
// Pixel-in / packed-word-out bus of the crop/pack block.
interface ov5640_crop_pack_if;
    logic        pix_en;
    logic [15:0] pix_data;
    logic        cam_hs;
    logic        cam_vs;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sof;
    logic        out_eol;
    logic        frame_done;
    logic        ovf;

    modport master (
        output pix_en, pix_data, cam_hs, cam_vs, out_ready,
        input  out_valid, out_data, out_sof, out_eol, frame_done, ovf
    );

    modport slave (
        input  pix_en, pix_data, cam_hs, cam_vs, out_ready,
        output out_valid, out_data, out_sof, out_eol, frame_done, ovf
    );
endinterface

// File: rtl/ov5640_crop_pack_fifo.sv
// crop_fifo: first-word-fall-through FIFO; the caller must not write when full
// unless it reads in the same cycle.
module crop_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_rd;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
        // Head reads as zero when empty so the outputs are clean after reset.
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/ov5640_crop_pack.sv
// Crops a window from the OV5640 RGB565 stream and packs pixel pairs into 32-bit words.
// Optional CROP_STATS_EN adds frame_cnt / drop_cnt statistics ports.
module ov5640_crop_pack
    import ov5640_pkg::*;
#(
    parameter int X_START    = 0,
    parameter int Y_START    = 0,
    parameter int CROP_W     = 320,
    parameter int CROP_H     = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               ov5640_pclk,
    input  logic               sys_rst,
`ifdef CROP_STATS_EN
    output logic [15:0]        frame_cnt,
    output logic [15:0]        drop_cnt,
`endif
    ov5640_crop_pack_if.slave  bus
);
    localparam int CW1 = COORD_W + 1;
    localparam logic [COORD_W:0]   X_LO    = CW1'(X_START);
    localparam logic [COORD_W:0]   X_HI    = CW1'(X_START + CROP_W);
    localparam logic [COORD_W:0]   Y_LO    = CW1'(Y_START);
    localparam logic [COORD_W:0]   Y_HI    = CW1'(Y_START + CROP_H);
    localparam logic [COORD_W-1:0] X_FIRST = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_FIRST = COORD_W'(Y_START);
    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(X_START + CROP_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(Y_START + CROP_H - 1);

    state_t               state_q, state_d;
    logic                 vs_q, hs_q;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic                 phase_q, phase_d;
    logic [15:0]          hi_q, hi_d;
    logic                 hi_sof_q, hi_sof_d;
    logic                 push_q, push_d;
    logic                 last_q, last_d;
    word_t                word_q, word_d;
    logic                 ovf_q, ovf_d;
    logic                 frame_done_q, frame_done_d;

    logic                 vs_fall, vs_rise, hs_fall, in_win, take;
    logic                 pop, fifo_wr, drop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0]    fifo_head;
    word_t                head;

    always_comb begin
        vs_fall = vs_q & ~bus.cam_vs;
        vs_rise = ~vs_q & bus.cam_vs;
        hs_fall = hs_q & ~bus.cam_hs;
        in_win  = ({1'b0, x_q} >= X_LO) && ({1'b0, x_q} < X_HI) &&
                  ({1'b0, y_q} >= Y_LO) && ({1'b0, y_q} < Y_HI);
        take    = (state_q == ACTIVE) && bus.pix_en && in_win;
        pop     = ~fifo_empty & bus.out_ready;
        // A word landing on a full FIFO is dropped unless the head leaves this cycle.
        fifo_wr = push_q & (~fifo_full | pop);
        drop    = push_q & fifo_full & ~pop;

        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        hi_sof_d     = hi_sof_q;
        push_d       = 1'b0;
        last_d       = 1'b0;
        word_d       = word_q;
        ovf_d        = ovf_q | drop;
        frame_done_d = 1'b0;

        case (state_q)
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (bus.pix_en) x_d = sat_inc(x_q);
                if (hs_fall) begin
                    x_d = '0;
                    y_d = sat_inc(y_q);
                end
                if (take) begin
                    if (!phase_q) begin
                        hi_d     = bus.pix_data;
                        hi_sof_d = (x_q == X_FIRST) && (y_q == Y_FIRST);
                        phase_d  = 1'b1;
                    end else begin
                        push_d      = 1'b1;
                        word_d.sof  = hi_sof_q;
                        word_d.eol  = (x_q == X_LAST);
                        word_d.data = {hi_q, bus.pix_data};
                        last_d      = (x_q == X_LAST) && (y_q == Y_LAST);
                        phase_d     = 1'b0;
                    end
                end
                if (vs_rise || (push_q && last_q)) begin
                    state_d = FLUSH;
                    phase_d = 1'b0;
                end
            end
            FLUSH: begin
                // A word still in the push register has not reached the FIFO yet.
                if (fifo_empty && !push_q) begin
                    state_d      = WAIT_VS;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= WAIT_VS;
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            hi_sof_q     <= 1'b0;
            push_q       <= 1'b0;
            last_q       <= 1'b0;
            word_q       <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= bus.cam_vs;
            hs_q         <= bus.cam_hs;
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            hi_sof_q     <= hi_sof_d;
            push_q       <= push_d;
            last_q       <= last_d;
            word_q       <= word_d;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_done_d;
        end
    end

    crop_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ov5640_pclk),
        .rst     (sys_rst),
        .wr_en   (fifo_wr),
        .wr_data (word_q),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head           = word_t'(fifo_head);
    assign bus.out_valid  = ~fifo_empty;
    assign bus.out_data   = head.data;
    assign bus.out_sof    = head.sof;
    assign bus.out_eol    = head.eol;
    assign bus.frame_done = frame_done_q;
    assign bus.ovf        = ovf_q;

`ifdef CROP_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(frame_done_d);
        drop_cnt_d  = (drop && drop_cnt_q != 16'hffff) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    // No statistics counters in this build.
`endif
endmodule

// File: tb/tb_ov5640_crop_pack.sv
// Directed bench for ov5640_crop_pack: window packing, overflow, backpressure, abort, reset, multi-frame.
module tb_ov5640_crop_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en, cam_hs, cam_vs;
    logic [15:0] pix_data;
    logic        rdy_a, rdy_b, tog;

    int checks = 0;
    int errors = 0;
    int fd_a = 0;
    int stab_err = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;

    logic [31:0] qa_data[$];
    logic        qa_sof[$];
    logic        qa_eol[$];
    logic [31:0] qb_data[$];

    logic [31:0] exp_a [4] = '{32'h01020103, 32'h01040105, 32'h02020203, 32'h02040205};
    logic        exp_s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        exp_e [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp_b [4] = '{32'h01020103, 32'h01040105, 32'h01060107, 32'h01080109};

    always #5 clk = ~clk;

    ov5640_crop_pack_if ia ();
    ov5640_crop_pack_if ib ();

    assign ia.pix_en = pix_en;  assign ib.pix_en = pix_en;
    assign ia.pix_data = pix_data;  assign ib.pix_data = pix_data;
    assign ia.cam_hs = cam_hs;  assign ib.cam_hs = cam_hs;
    assign ia.cam_vs = cam_vs;  assign ib.cam_vs = cam_vs;
    assign ia.out_ready = rdy_a;
    assign ib.out_ready = rdy_b;

`ifdef CROP_STATS_EN
    logic [15:0] fc_a, dc_a, fc_b, dc_b;
`endif

    ov5640_crop_pack #(.X_START(2), .Y_START(1), .CROP_W(4), .CROP_H(2), .FIFO_DEPTH(16)) dut_a (
        .ov5640_pclk (clk),
        .sys_rst     (rst),
`ifdef CROP_STATS_EN
        .frame_cnt   (fc_a),
        .drop_cnt    (dc_a),
`endif
        .bus         (ia)
    );

    ov5640_crop_pack #(.X_START(2), .Y_START(1), .CROP_W(12), .CROP_H(1), .FIFO_DEPTH(4)) dut_b (
        .ov5640_pclk (clk),
        .sys_rst     (rst),
`ifdef CROP_STATS_EN
        .frame_cnt   (fc_b),
        .drop_cnt    (dc_b),
`endif
        .bus         (ib)
    );

    // Transfers are recorded half a cycle before the edge that performs them.
    always @(negedge clk) begin
        if (ia.out_valid && rdy_a) begin
            qa_data.push_back(ia.out_data);
            qa_sof.push_back(ia.out_sof);
            qa_eol.push_back(ia.out_eol);
        end
        if (ib.out_valid && rdy_b) qb_data.push_back(ib.out_data);
        if (ia.frame_done) fd_a++;
        if (!rst && pv && !pr && (!ia.out_valid || ia.out_data !== pd)) stab_err++;
        pv = ia.out_valid && !rst;
        pr = rdy_a;
        pd = ia.out_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) rdy_a = ~rdy_a;
    endtask

    task automatic pixels(input int y, input int x0, input int n);
        cam_hs = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_en   = 1'b1;
            pix_data = 16'(x0 + i + 256 * y);
            step();
        end
        pix_en = 1'b0;
    endtask

    task automatic end_line();
        cam_hs = 1'b0;
        step();
        step();
    endtask

    task automatic full_line(input int y);
        pixels(y, 0, 640);
        end_line();
    endtask

    task automatic frame_start();
        cam_vs = 1'b1;
        repeat (3) step();
        cam_vs = 1'b0;
        repeat (3) step();
    endtask

    task automatic frame_end();
        cam_vs = 1'b1;
        repeat (3) step();
    endtask

    task automatic full_frame();
        frame_start();
        for (int y = 0; y < 4; y++) full_line(y);
        frame_end();
        repeat (10) step();
    endtask

    task automatic clear_q();
        qa_data.delete(); qa_sof.delete(); qa_eol.delete(); qb_data.delete();
        fd_a = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ia.out_valid); end
        checks++; if (ia.out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", ia.out_data); end
        checks++; if ({ia.out_sof, ia.out_eol} !== 2'b00) begin errors++; $display("FAIL rst_sof_eol got %b want 00", {ia.out_sof, ia.out_eol}); end
        checks++; if ({ia.frame_done, ia.ovf} !== 2'b00) begin errors++; $display("FAIL rst_fd_ovf got %b want 00", {ia.frame_done, ia.ovf}); end
        checks++; if (ib.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_b got %b want 0", ib.out_valid); end
`ifdef CROP_STATS_EN
        checks++; if ({fc_a, dc_a} !== 32'h0) begin errors++; $display("FAIL rst_stats got %h want 0", {fc_a, dc_a}); end
`endif
        rst = 1'b0;
        repeat (3) step();
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", ia.out_valid); end
    endtask

    task automatic test_basic_frame();
        clear_q();
        full_frame();
        checks++; if (qa_data.size() !== 4) begin errors++; $display("FAIL basic_count got %0d want 4", qa_data.size()); end
        for (int i = 0; i < 4 && i < qa_data.size(); i++) begin
            checks++;
            if (qa_data[i] !== exp_a[i] || qa_sof[i] !== exp_s[i] || qa_eol[i] !== exp_e[i]) begin
                errors++;
                $display("FAIL basic_word%0d got %h sof %b eol %b want %h sof %b eol %b",
                         i, qa_data[i], qa_sof[i], qa_eol[i], exp_a[i], exp_s[i], exp_e[i]);
            end
        end
        checks++; if (fd_a !== 1) begin errors++; $display("FAIL basic_frame_done got %0d want 1", fd_a); end
        checks++; if (ia.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ia.ovf); end
    endtask

    task automatic test_overflow();
        clear_q();
        rdy_b = 1'b0;
        frame_start();
        full_line(0);
        pixels(1, 0, 10);
        repeat (3) step();
        checks++; if ({ib.out_valid, ib.ovf} !== 2'b10) begin errors++; $display("FAIL ovf_held got valid/ovf %b want 10", {ib.out_valid, ib.ovf}); end
        checks++; if (ib.out_data !== 32'h01020103 || ib.out_sof !== 1'b1) begin errors++; $display("FAIL ovf_head got %h sof %b want 01020103 sof 1", ib.out_data, ib.out_sof); end
        pixels(1, 10, 630);
        end_line();
        checks++; if (ib.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ib.ovf); end
        checks++; if (ib.out_data !== 32'h01020103) begin errors++; $display("FAIL ovf_head_kept got %h want 01020103", ib.out_data); end
        full_line(2);
        full_line(3);
        frame_end();
`ifdef CROP_STATS_EN
        checks++; if (dc_b !== 16'd2) begin errors++; $display("FAIL drop_cnt got %0d want 2", dc_b); end
`endif
        rdy_b = 1'b1;
        repeat (10) step();
        checks++; if (qb_data.size() !== 4) begin errors++; $display("FAIL ovf_count got %0d want 4", qb_data.size()); end
        for (int i = 0; i < 4 && i < qb_data.size(); i++) begin
            checks++;
            if (qb_data[i] !== exp_b[i]) begin errors++; $display("FAIL ovf_word%0d got %h want %h", i, qb_data[i], exp_b[i]); end
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        stab_err = 0;
        tog = 1'b1;
        full_frame();
        tog = 1'b0;
        rdy_a = 1'b1;
        repeat (10) step();
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
        checks++; if (qa_data.size() !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", qa_data.size()); end
        for (int i = 0; i < 4 && i < qa_data.size(); i++) begin
            checks++;
            if (qa_data[i] !== exp_a[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, qa_data[i], exp_a[i]); end
        end
    endtask

    task automatic test_vs_abort();
        clear_q();
        frame_start();
        full_line(0);
        pixels(1, 0, 3);
        frame_end();
        cam_hs = 1'b0;
        repeat (10) step();
        checks++; if (qa_data.size() !== 0) begin errors++; $display("FAIL abort_count got %0d want 0", qa_data.size()); end
        checks++; if (fd_a !== 1) begin errors++; $display("FAIL abort_frame_done got %0d want 1", fd_a); end
        full_frame();
        checks++; if (qa_data.size() !== 4) begin errors++; $display("FAIL abort_next_count got %0d want 4", qa_data.size()); end
        if (qa_data.size() > 0) begin
            checks++;
            if (qa_data[0] !== 32'h01020103 || qa_sof[0] !== 1'b1) begin errors++; $display("FAIL abort_next_first got %h sof %b want 01020103 sof 1", qa_data[0], qa_sof[0]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        rdy_a = 1'b0;
        frame_start();
        full_line(0);
        full_line(1);
        pixels(2, 0, 4);
        repeat (3) step();
        checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered got %b want 1", ia.out_valid); end
        rst = 1'b1;
        step();
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_cleared got %b want 0", ia.out_valid); end
        rst = 1'b0;
        rdy_a = 1'b1;
        pixels(2, 4, 636);
        end_line();
        full_line(3);
        repeat (5) step();
        checks++; if (qa_data.size() !== 0 || ia.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_silent got %0d words valid %b want 0 words valid 0", qa_data.size(), ia.out_valid); end
        full_frame();
        checks++; if (qa_data.size() !== 4) begin errors++; $display("FAIL rmid_next_count got %0d want 4", qa_data.size()); end
        if (qa_data.size() > 0) begin
            checks++;
            if (qa_data[0] !== 32'h01020103) begin errors++; $display("FAIL rmid_next_first got %h want 01020103", qa_data[0]); end
        end
    endtask

    task automatic test_multi_frame();
        int sofs;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        clear_q();
        rdy_b = 1'b0;
        full_frame();
        checks++; if (ib.ovf !== 1'b1) begin errors++; $display("FAIL multi_ovf1 got %b want 1", ib.ovf); end
        rdy_b = 1'b1;
        repeat (10) step();
        frame_start();
        full_line(0);
        checks++; if (ib.ovf !== 1'b0) begin errors++; $display("FAIL multi_ovf_clear got %b want 0", ib.ovf); end
        for (int y = 1; y < 4; y++) full_line(y);
        frame_end();
        repeat (10) step();
        full_frame();
        sofs = 0;
        foreach (qa_sof[i]) if (qa_sof[i] === 1'b1) sofs++;
        checks++; if (qa_data.size() !== 12) begin errors++; $display("FAIL multi_count got %0d want 12", qa_data.size()); end
        checks++; if (sofs !== 3) begin errors++; $display("FAIL multi_sof got %0d want 3", sofs); end
        for (int f = 0; f < 3 && 4 * f < qa_sof.size(); f++) begin
            checks++;
            if (qa_sof[4 * f] !== 1'b1) begin errors++; $display("FAIL multi_sof_pos%0d got %b want 1", f, qa_sof[4 * f]); end
        end
        checks++; if (fd_a !== 3) begin errors++; $display("FAIL multi_frame_done got %0d want 3", fd_a); end
        checks++; if (ib.ovf !== 1'b0) begin errors++; $display("FAIL multi_ovf3 got %b want 0", ib.ovf); end
`ifdef CROP_STATS_EN
        checks++; if (fc_a !== 16'd3) begin errors++; $display("FAIL frame_cnt got %0d want 3", fc_a); end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        cam_vs   = 1'b1;
        cam_hs   = 1'b0;
        pix_en   = 1'b0;
        pix_data = '0;
        rdy_a    = 1'b1;
        rdy_b    = 1'b1;
        tog      = 1'b0;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_backpressure();
        test_vs_abort();
        test_reset_mid();
        test_multi_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
